ring_osc_sweeper: RTL and testbench
===================================

# ring_osc_sweeper

Measurement sequencer for the tapped ring oscillator. It runs in the `clk` domain and steps the ring's tap select through the enabled taps. For each tap it opens the oscillator enable for a fixed window of `clk` cycles, waits for the free-running edge counter to freeze, and captures the count. It then presents the result as a (tap, count) record on a valid/ready port, replacing manual toggling of the enable pin with a repeatable, `clk`-timed frequency sweep.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 1024: `clk` cycles `osc_en` is held high per tap (≥1).
- `SETUP_CYCLES`, default 2: `clk` cycles `tap_sel` is stable with `osc_en` low before the window opens (≥1).
- `SETTLE_CYCLES`, default 4: minimum `clk` cycles after the window closes before count sampling starts (≥1).

Ports:
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  reset, synchronous and active-high.
- `start`  input  1  begin a sweep; sampled only in IDLE.
- `tap_mask`  input  8  bit i=1 → measure tap i; sampled at start acceptance.
- `tap_sel`  output  3  drives the ring tap select.
- `osc_en`  output  1  drives the oscillator enable/gate.
- `count_in`  input  15  raw edge count from the oscillator domain; valid only while `osc_en`=0.
- `res_valid`  output  1  result available.
- `res_ready`  input  1  consumer accepts result.
- `res_tap`  output  3  tap of the current result.
- `res_count`  output  15  captured count.
- `res_dead`  output  1  captured count == 0 (oscillator not running).
- `busy`  output  1  sweep in progress.
- `done`  output  1  one-cycle pulse at sweep end.

## Operation
- States: IDLE → SELECT → GATE → SETTLE → OUTPUT → (SELECT for next tap | FINISH) → IDLE.
- IDLE: `start`=1 latches `tap_mask` and moves to the lowest set tap. If the mask is 0, go straight to FINISH.
- SELECT: `tap_sel`=current tap, `osc_en`=0, for SETUP_CYCLES cycles.
- GATE: `osc_en`=1 for exactly WINDOW_CYCLES cycles. The oscillator domain clears its counter on the enable rising edge, so this block issues no clear.
- SETTLE: `osc_en`=0. `count_in` passes through a 2-flop capture stage. After SETTLE_CYCLES cycles, the block compares the capture-stage output with its previous value each cycle. The first cycle the two match, that value is captured and the FSM moves to OUTPUT. There is no timeout: with the enable low the count is guaranteed to freeze.
- OUTPUT: `res_valid`=1; `res_tap`, `res_count` and `res_dead` are held stable until `res_valid`&`res_ready`. After the transfer, go to the next higher set tap, or to FINISH if none remain.
- FINISH: `done`=1 for one cycle, then IDLE.
- `start` is ignored outside IDLE. `tap_mask` changes after acceptance have no effect.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: `tap_sel`=0, `osc_en`=0, `res_valid`=0, `res_tap`=0, `res_count`=0, `res_dead`=0, `busy`=0, `done`=0; state=IDLE.
- `rst` mid-sweep: all outputs take reset values at the same edge, including `osc_en` dropping, and the pending result is discarded.
- All outputs are registered.
- `start` sampled at edge N → `busy`=1 and state=SELECT after edge N; `osc_en` rises SETUP_CYCLES cycles later.
- Per tap, with the count stable on first compare: SETUP + WINDOW + SETTLE + 3 cycles to `res_valid`.
- `res_ready` held high: the transfer takes 1 cycle; the next SELECT starts the following cycle.
- Mask 0: `done` pulses 2 cycles after start acceptance; `res_valid` is never asserted.
- Counter width is 15 bits. The oscillator counter wraps mod 2^15, and so does the reported count. No overflow detection; WINDOW_CYCLES must be sized to avoid wrap.

## Structure
- Package `ring_osc_pkg`: FSM state enum, `COUNT_W`=15, `TAP_W`=3, `NUM_TAPS`=8.
- Sub-module `ring_count_sampler`: 2-flop capture of `count_in`, previous-value compare, and `stable` flag. The FSM owns its timers and tap-select logic.

## Test plan
Bench uses WINDOW=16, SETUP=2, SETTLE=4 and a behavioral ring counting 3 edges per `clk` while `osc_en`=1.
- `tap_mask`=0x01, `start` pulse, `res_ready`=1 → one result: tap=0, count=48, `res_dead`=0; `done` pulse follows; `osc_en` high exactly 16 cycles.
- `tap_mask`=0xA5 → results for taps 0, 2, 5, 7 in order, then `done`; `tap_sel` never shows a masked tap while `osc_en`=1.
- `res_ready` held low 10 cycles in OUTPUT → `res_valid` and data stable for all 10 cycles, no second SELECT; the transfer completes on the first ready cycle.
- Ring model with dead oscillator (0 edges) → count=0, `res_dead`=1. Model with count still changing for 3 cycles after the enable falls → capture waits until two equal consecutive samples.
- `tap_mask`=0x00 → `done` 2 cycles after start, no `res_valid`. `start` asserted while busy → ignored, with no restart or extra results.
- `rst` asserted during GATE → next cycle `osc_en`=0, `busy`=0, `res_valid`=0. A subsequent `start` runs a clean sweep.

Source files
------------

// File: rtl/ring_osc_pkg.sv
// Shared types and helpers for the ring-oscillator frequency sweeper.
package ring_osc_pkg;

    localparam int unsigned COUNT_W  = 15;
    localparam int unsigned TAP_W    = 3;
    localparam int unsigned NUM_TAPS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_GATE,
        ST_SETTLE,
        ST_OUTPUT,
        ST_FINISH
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [TAP_W-1:0] lowest_tap(input logic [NUM_TAPS-1:0] mask);
        logic [TAP_W-1:0] tap;
        tap = '0;
        for (int i = NUM_TAPS - 1; i >= 0; i--) begin
            if (mask[i]) tap = TAP_W'(i);
        end
        return tap;
    endfunction

    function automatic logic [NUM_TAPS-1:0] tap_bit(input logic [TAP_W-1:0] tap);
        return NUM_TAPS'(1) << tap;
    endfunction

endpackage

// File: rtl/ring_count_sampler.sv
// Two-flop capture of the oscillator-domain count plus a registered
// "same value as last cycle" flag used to detect that the count has frozen.
module ring_count_sampler
    import ring_osc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] count_in,
    output logic [COUNT_W-1:0] sample,
    output logic               stable
);

    logic [COUNT_W-1:0] stage1;

    // stable compares the value entering sample with the one it replaces
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1 <= '0;
            sample <= '0;
            stable <= 1'b0;
        end else begin
            stage1 <= count_in;
            sample <= stage1;
            stable <= (stage1 == sample);
        end
    end

endmodule

// File: rtl/ring_osc_sweeper.sv
// Steps the ring tap select through the enabled taps, gates the oscillator
// for a fixed window per tap and reports each frozen edge count.
module ring_osc_sweeper
    import ring_osc_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_TAPS-1:0] tap_mask,
    output logic [TAP_W-1:0]    tap_sel,
    output logic                osc_en,
    input  logic [COUNT_W-1:0]  count_in,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [TAP_W-1:0]    res_tap,
    output logic [COUNT_W-1:0]  res_count,
    output logic                res_dead,
    output logic                busy,
    output logic                done
);

    // Two extra cycles cover the capture-stage fill before compares are trusted.
    localparam int unsigned SETTLE_WAIT = SETTLE_CYCLES + 2;
    localparam int unsigned MAX_A       = (WINDOW_CYCLES > SETUP_CYCLES) ? WINDOW_CYCLES : SETUP_CYCLES;
    localparam int unsigned MAX_T       = (MAX_A > SETTLE_WAIT) ? MAX_A : SETTLE_WAIT;
    localparam int unsigned TIMER_W     = $clog2(MAX_T + 1);

    state_t              state;
    logic [TIMER_W-1:0]  timer;
    logic [NUM_TAPS-1:0] pending;
    logic [COUNT_W-1:0]  sample;
    logic                stable;

    ring_count_sampler u_sampler (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .sample   (sample),
        .stable   (stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            pending   <= '0;
            tap_sel   <= '0;
            osc_en    <= 1'b0;
            res_valid <= 1'b0;
            res_tap   <= '0;
            res_count <= '0;
            res_dead  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        timer <= '0;
                        if (tap_mask == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            state   <= ST_SELECT;
                            tap_sel <= lowest_tap(tap_mask);
                            pending <= tap_mask & ~tap_bit(lowest_tap(tap_mask));
                        end
                    end
                end
                ST_SELECT: begin
                    if (timer == TIMER_W'(SETUP_CYCLES - 1)) begin
                        timer  <= '0;
                        osc_en <= 1'b1;
                        state  <= ST_GATE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_GATE: begin
                    if (timer == TIMER_W'(WINDOW_CYCLES - 1)) begin
                        timer  <= '0;
                        osc_en <= 1'b0;
                        state  <= ST_SETTLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // No timeout: with the gate closed the count must freeze.
                    if (timer != TIMER_W'(SETTLE_WAIT)) begin
                        timer <= timer + 1'b1;
                    end else if (stable) begin
                        res_valid <= 1'b1;
                        res_tap   <= tap_sel;
                        res_count <= sample;
                        res_dead  <= (sample == '0);
                        state     <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        timer     <= '0;
                        if (pending != '0) begin
                            state   <= ST_SELECT;
                            tap_sel <= lowest_tap(pending);
                            pending <= pending & ~tap_bit(lowest_tap(pending));
                        end else begin
                            state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_sweeper.sv
// Scoreboard bench: a behavioural ring counter feeds the sweeper, expected
// (tap, count, dead) records are queued per sweep and checked by a monitor.
module tb_ring_osc_sweeper;
    import ring_osc_pkg::*;

    localparam int unsigned WIN    = 16;
    localparam int unsigned SETUP  = 2;
    localparam int unsigned SETTLE = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [NUM_TAPS-1:0] tap_mask = '0;
    logic [TAP_W-1:0]    tap_sel;
    logic                osc_en;
    logic [COUNT_W-1:0]  count_in;
    logic                res_valid;
    logic                res_ready = 1'b1;
    logic [TAP_W-1:0]    res_tap;
    logic [COUNT_W-1:0]  res_count;
    logic                res_dead;
    logic                busy;
    logic                done;

    ring_osc_sweeper #(
        .WINDOW_CYCLES (WIN),
        .SETUP_CYCLES  (SETUP),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tap_mask  (tap_mask),
        .tap_sel   (tap_sel),
        .osc_en    (osc_en),
        .count_in  (count_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_tap   (res_tap),
        .res_count (res_count),
        .res_dead  (res_dead),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural ring: cleared on enable rise, edges_per_clk per enabled
    // cycle, then drift_cycles extra single edges after the gate closes.
    int                 edges_per_clk = 3;
    int                 drift_cycles  = 0;
    logic [COUNT_W-1:0] ring_cnt = '0;
    logic               en_d = 1'b0;
    int                 tail = 0;

    always @(posedge clk) begin
        if (osc_en) begin
            ring_cnt <= en_d ? ring_cnt + COUNT_W'(edges_per_clk) : COUNT_W'(edges_per_clk);
            tail     <= drift_cycles;
        end else if (tail > 0) begin
            ring_cnt <= ring_cnt + COUNT_W'(1);
            tail     <= tail - 1;
        end
        en_d <= osc_en;
    end
    assign count_in = ring_cnt;

    typedef struct {
        int tap;
        int count;
        int dead;
        int drift;
    } exp_t;
    exp_t q[$];

    logic [NUM_TAPS-1:0] cur_mask = '0;

    task automatic push_expected(input logic [NUM_TAPS-1:0] mask, input int edges, input int drift);
        exp_t e;
        for (int t = 0; t < int'(NUM_TAPS); t++) begin
            if (mask[t]) begin
                e.tap   = t;
                e.count = (edges * int'(WIN) + drift) % 32768;
                e.dead  = (e.count == 0) ? 1 : 0;
                e.drift = drift;
                q.push_back(e);
            end
        end
    endtask

    // Consumer: 0 = always ready, 1 = random, 2 = stall 10 cycles per result.
    int ready_mode = 0;
    int stall_cnt  = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: res_ready = 1'($urandom_range(0, 1));
            2: begin
                if (!res_valid) begin
                    stall_cnt = 0;
                    res_ready = 1'b0;
                end else if (stall_cnt < 10) begin
                    stall_cnt++;
                    res_ready = 1'b0;
                end else begin
                    res_ready = 1'b1;
                end
            end
            default: res_ready = 1'b1;
        endcase
    end

    // Monitor: window length, tap legality, result latency, data and handshake.
    logic osc_prev   = 1'b0;
    int   run_len    = 0;
    int   tap_bad    = 0;
    int   waiting    = 0;
    int   fall_cnt   = 0;
    int   after_xfer = 0;
    int   done_cnt   = 0;
    int   lat;

    always @(negedge clk) begin
        if (rst) begin
            osc_prev   = 1'b0;
            run_len    = 0;
            tap_bad    = 0;
            waiting    = 0;
            after_xfer = 0;
        end else begin
            if (osc_en) begin
                run_len++;
                if (!cur_mask[tap_sel]) tap_bad = 1;
            end else if (osc_prev) begin
                check("osc_window_len", run_len, int'(WIN));
                check("tap_in_mask", tap_bad, 0);
                run_len  = 0;
                tap_bad  = 0;
                waiting  = 1;
                fall_cnt = 0;
            end
            if (waiting != 0) fall_cnt++;
            if (after_xfer != 0) check("valid_drop_after_xfer", int'(res_valid), 0);
            if (res_valid) begin
                check("no_gate_while_valid", int'(osc_en), 0);
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got tap %0d count %0d, expected none", res_tap, res_count);
                end else begin
                    if (waiting != 0) begin
                        lat = fall_cnt - 1;
                        if (q[0].drift == 0) check("result_latency", lat, int'(SETTLE) + 3);
                        else check("result_latency_min", int'(lat >= int'(SETTLE) + 3), 1);
                        waiting = 0;
                    end
                    check("res_tap", int'(res_tap), q[0].tap);
                    check("res_count", int'(res_count), q[0].count);
                    check("res_dead", int'(res_dead), q[0].dead);
                    if (res_ready) void'(q.pop_front());
                end
            end
            after_xfer = (res_valid && res_ready) ? 1 : 0;
            if (done) done_cnt++;
            osc_prev = osc_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input logic [NUM_TAPS-1:0] mask, input int edges, input int drift,
                             input int rmode, input bit poke_start);
        int d0;
        edges_per_clk = edges;
        drift_cycles  = drift;
        ready_mode    = rmode;
        cur_mask      = mask;
        push_expected(mask, edges, drift);
        d0       = done_cnt;
        tap_mask = mask;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tap_mask = NUM_TAPS'($urandom());
        check("busy_after_start", int'(busy), 1);
        for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
            tick();
            if (poke_start && i == 20) begin
                start    = 1'b1;
                tap_mask = '1;
                tick();
                start = 1'b0;
            end
        end
        check("sweep_done", done_cnt - d0, 1);
        repeat (3) tick();
        check("single_done", done_cnt - d0, 1);
        check("queue_drained", q.size(), 0);
        check("idle_after_sweep", int'(busy), 0);
        q.delete();
    endtask

    initial begin
        repeat (2) tick();
        check("rst_tap_sel", int'(tap_sel), 0);
        check("rst_osc_en", int'(osc_en), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_tap", int'(res_tap), 0);
        check("rst_res_count", int'(res_count), 0);
        check("rst_res_dead", int'(res_dead), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        tick();

        run_sweep(8'h01, 3, 0, 0, 1'b0);     // single tap, count 48
        run_sweep(8'hA5, 3, 0, 0, 1'b0);     // taps 0,2,5,7 in order
        run_sweep(8'h01, 3, 0, 2, 1'b0);     // consumer stalls 10 cycles
        run_sweep(8'h18, 0, 0, 0, 1'b0);     // dead oscillator
        run_sweep(8'h02, 3, 6, 0, 1'b0);     // count still moving after gate closes
        run_sweep(8'h81, 2, 0, 0, 1'b1);     // start pulse mid-sweep is ignored

        // Empty mask: done in the second cycle after the start cycle, no result.
        ready_mode = 0;
        cur_mask   = '0;
        tap_mask   = '0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("mask0_busy", int'(busy), 1);
        check("mask0_done_early", int'(done), 0);
        tick();
        check("mask0_done", int'(done), 1);
        check("mask0_no_valid", int'(res_valid), 0);
        tick();
        check("mask0_done_pulse", int'(done), 0);

        // Reset in the middle of the gate window.
        edges_per_clk = 3;
        drift_cycles  = 0;
        cur_mask      = 8'h01;
        tap_mask      = 8'h01;
        start         = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && !osc_en; i++) tick();
        check("gate_reached", int'(osc_en), 1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst_osc_en", int'(osc_en), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_res_valid", int'(res_valid), 0);
        rst = 1'b0;
        q.delete();
        tick();
        run_sweep(8'h01, 3, 0, 0, 1'b0);

        // Random sweeps against the arithmetic model.
        for (int k = 0; k < 6; k++) begin
            run_sweep(NUM_TAPS'($urandom_range(1, 255)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
